// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset PC, NOP word and queue entry type for the fetch stage
package fetch_pkg;
  localparam int ADDR_W = 12;
  localparam int RESET_PC = 0;
  localparam logic [31:0] NOP_WORD = 32'h0;
  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue2.sv
// fetch_queue2: 2-entry FIFO of fetched words with synchronous flush and head/count outputs
module fetch_queue2
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  entry_t     push_data_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output logic [1:0] count_o,
  output entry_t     head_o
);
  entry_t     mem_q [2];
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;
  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & (count_q != 2'd0) & ~flush_i;
  assign count_d = flush_i ? 2'd0 : count_q + {1'b0, do_push} - {1'b0, do_pop};
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (do_push) begin
          mem_q[wr_ptr_q] <= push_data_i;
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end
  // The parent's credit rule must never let a response land in a full queue
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(do_push && count_q == 2'd2));
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencing, synchronous imem access and a 2-deep output queue
// feeding the decoder over valid/ready, with redirect flush.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = fetch_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(fetch_pkg::RESET_PC),
  parameter int                DEPTH    = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_q,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instruction,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_plus1
);
  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        count;
  logic [2:0]        occupancy;
  logic              pop, push, issue;
  entry_t            head, resp;
  assign pop       = out_valid & out_ready;
  // Words queued plus the one in flight, net of this cycle's pop, must leave room for another
  assign occupancy = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue     = ~redirect_valid & (occupancy < 3'(DEPTH));
  assign push      = inflight_q & ~redirect_valid;
  assign resp      = '{instr: imem_q, pc: inflight_pc_q};
  always_comb begin
    fetch_pc_d    = redirect_valid ? redirect_pc : issue ? fetch_pc_q + ADDR_W'(1) : fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end
  fetch_queue2 #(.entry_t(entry_t)) u_queue (
    .clk_i      (clock),
    .rst_ni     (reset),
    .push_i     (push),
    .push_data_i(resp),
    .pop_i      (pop),
    .flush_i    (redirect_valid),
    .count_o    (count),
    .head_o     (head)
  );
  assign imem_addr       = fetch_pc_q;
  assign out_valid       = count != 2'd0;
  assign out_instruction = out_valid ? head.instr : NOP_WORD;
  assign out_pc          = out_valid ? head.pc : '0;
  assign out_pc_plus1    = out_valid ? head.pc + ADDR_W'(1) : '0;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed stimulus with a scoreboard of expected accepted PCs
// and a negedge monitor that checks every handshake and every stalled cycle.
module tb_instruction_fetch;
  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] imem_addr;
  logic [31:0] imem_q;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [11:0] out_pc;
  logic [11:0] out_pc_plus1;
  int          checks = 0;
  int          failures = 0;
  logic [11:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [11:0] prev_pc;
  logic [31:0] prev_instr;

  instruction_fetch u_dut (
    .clock          (clock),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_q         (imem_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instruction(out_instruction),
    .out_pc         (out_pc),
    .out_pc_plus1   (out_pc_plus1)
  );

  always #5 clock = ~clock;
  always @(posedge clock) imem_q <= 32'h1000_0000 + {20'h0, imem_addr};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_pc(input logic [11:0] pc);
    logic found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (out_valid && out_pc == pc) found = 1'b1;
      else step();
    end
    check($sformatf("wait_pc_%0h", pc), {31'b0, found}, 32'd1);
  endtask

  task automatic expect_pcs(input logic [11:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 12'(i));
  endtask

  always @(negedge clock) begin
    if (!reset) stall_prev = 1'b0;
    else begin
      if (stall_prev) begin
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_pc", {20'h0, out_pc}, {20'h0, prev_pc});
        check("stall_instr", out_instruction, prev_instr);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_handshake actual_pc=%0h required=none", out_pc);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          check("out_pc", {20'h0, out_pc}, {20'h0, e});
          check("out_instruction", out_instruction, 32'h1000_0000 + {20'h0, e});
          check("out_pc_plus1", {20'h0, out_pc_plus1}, {20'h0, e + 12'd1});
        end
      end
      stall_prev = out_valid && !out_ready && !redirect_valid;
      prev_pc    = out_pc;
      prev_instr = out_instruction;
    end
  end

  initial begin
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b1;
    repeat (3) step();
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_imem_addr", {20'h0, imem_addr}, 32'd0);
    check("rst_instr", out_instruction, 32'd0);
    check("rst_pc", {20'h0, out_pc}, 32'd0);
    check("rst_pc_plus1", {20'h0, out_pc_plus1}, 32'd0);
    expect_pcs(12'h000, 4);
    reset = 1'b1;
    step();
    check("lat_valid_c1", {31'b0, out_valid}, 32'd0);
    step();
    check("lat_valid_c2", {31'b0, out_valid}, 32'd1);
    check("lat_pc_c2", {20'h0, out_pc}, 32'd0);
    wait_pc(12'h004);
    out_ready = 1'b0;
    repeat (5) step();
    check("stall_out_pc", {20'h0, out_pc}, 32'h4);
    check("stall_imem_addr", {20'h0, imem_addr}, 32'h6);
    check("stall_count", {30'h0, u_dut.u_queue.count_o}, 32'd2);
    expect_pcs(12'h004, 4);
    out_ready = 1'b1;
    wait_pc(12'h008);
    out_ready = 1'b0;
    step();
    check("full_count", {30'h0, u_dut.u_queue.count_o}, 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 12'h100;
    step();
    redirect_valid = 1'b0;
    check("redir_valid_n1", {31'b0, out_valid}, 32'd0);
    step();
    check("redir_valid_n2", {31'b0, out_valid}, 32'd0);
    step();
    check("redir_valid_n3", {31'b0, out_valid}, 32'd1);
    check("redir_pc_n3", {20'h0, out_pc}, 32'h100);
    expect_pcs(12'h100, 2);
    out_ready = 1'b1;
    wait_pc(12'h102);
    out_ready = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 12'hffe;
    step();
    redirect_valid = 1'b0;
    expect_pcs(12'hffe, 4);
    out_ready = 1'b1;
    wait_pc(12'h002);
    out_ready = 1'b0;
    step();
    expect_pcs(12'h002, 1);
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 12'h020;
    step();
    check("simul_valid", {31'b0, out_valid}, 32'd0);
    check("simul_count", {30'h0, u_dut.u_queue.count_o}, 32'd0);
    redirect_pc = 12'h040;
    step();
    redirect_valid = 1'b0;
    expect_pcs(12'h040, 2);
    wait_pc(12'h042);
    out_ready = 1'b0;
    repeat (2) step();
    check("pre_areset_valid", {31'b0, out_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("areset_valid", {31'b0, out_valid}, 32'd0);
    check("areset_pc", {20'h0, out_pc}, 32'd0);
    check("areset_instr", out_instruction, 32'd0);
    check("areset_imem_addr", {20'h0, imem_addr}, 32'd0);
    repeat (2) step();
    reset = 1'b1;
    expect_pcs(12'h000, 3);
    out_ready = 1'b1;
    wait_pc(12'h003);
    out_ready = 1'b0;
    repeat (3) step();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
